// File: rtl/ins_pkg.sv
// ins_pkg
//   Shared definitions for the instruction fetch unit: FSM state encoding,
//   default geometry constants and the optional boot image.
//   Boot image contents are used only when INS_BOOT_IMAGE_EN is defined.
package ins_pkg;

    // Default geometry: 16-bit instructions, 64 words, 8-bit byte address.
    localparam int unsigned DefaultIw    = 16;
    localparam int unsigned DefaultDepth = 64;
    localparam int unsigned DefaultAw    = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } ins_state_e;

    // Boot image written into words 0..BootWords-1 on reset (zero-extended to IW).
    localparam int unsigned BootWords = 10;
    localparam int unsigned BootIdxW  = $clog2(BootWords);

    localparam logic [15:0] BootImage [BootWords] = '{
        16'hF120, 16'hF121, 16'h93FF, 16'h834C, 16'hF564,
        16'hF155, 16'hFFF1, 16'hF487, 16'hF468, 16'h9402
    };

    // Boot word for a memory index; zero beyond the end of the image.
    function automatic logic [15:0] boot_word(input int unsigned idx);
        logic [15:0] w_word;
        w_word = '0;
        if (idx < BootWords) begin
            w_word = BootImage[idx[BootIdxW-1:0]];
        end
        return w_word;
    endfunction

endpackage

// File: rtl/ins_mem.sv
// ins_mem
//   Instruction storage: one write port, one synchronous read port with a
//   read-enable so the read register can hold its value across stalls.
//   Macro: INS_BOOT_IMAGE_EN -- when defined, reset loads the boot image into
//   the array; otherwise the array is only written through the write port.
// Ports
//   clk      clock
//   rst      asynchronous active-high reset (clears the read register)
//   i_we     write strobe
//   i_waddr  write word index
//   i_wdata  write data
//   i_re     read enable; o_rdata holds when low
//   i_raddr  read word index
//   o_rdata  registered read data
module ins_mem
    import ins_pkg::*;
#(
    parameter int unsigned IW    = DefaultIw,
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned WAW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_we,
    input  logic [WAW-1:0] i_waddr,
    input  logic [IW-1:0]  i_wdata,
    input  logic           i_re,
    input  logic [WAW-1:0] i_raddr,
    output logic [IW-1:0]  o_rdata
);

    logic [IW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_rdata;

`ifdef INS_BOOT_IMAGE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[WAW'(i)] <= IW'(boot_word(i));
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end
`else
    // No reset on the array: contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit
//   Sequential instruction fetcher with program-load port, stall, redirect
//   and sticky range/alignment fault. FSM: IDLE -> RUN -> (IDLE | HALT).
//   Macro: INS_BOOT_IMAGE_EN (handled in ins_mem) preloads a boot image on reset.
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   ld_en/ld_addr/ld_data program load (honoured only in IDLE)
//   start, stop           begin fetching at byte 0 / return to IDLE
//   stall                 hold PC and outputs
//   redir_valid/addr      branch redirect to a byte address
//   out_valid/instr/pc    fetched instruction and its byte address
//   fault                 sticky range/alignment fault (state HALT)
//   busy                  high while in RUN
module ins_fetch_unit
    import ins_pkg::*;
#(
    parameter int unsigned IW    = DefaultIw,
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned AW    = DefaultAw
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [IW-1:0]            ld_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     stall,
    input  logic                     redir_valid,
    input  logic [AW-1:0]            redir_addr,
    output logic                     out_valid,
    output logic [IW-1:0]            out_instr,
    output logic [AW-1:0]            out_pc,
    output logic                     fault,
    output logic                     busy
);

    localparam int unsigned WAW = $clog2(DEPTH);
    localparam int unsigned BPI = IW / 8;

    ins_state_e    r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_out_pc;
    logic          r_out_valid;
    logic          r_fault;

    logic [AW-1:0]  w_word_idx;
    logic           w_in_range;
    logic           w_redir_misaligned;
    logic           w_fetch;
    logic           w_mem_we;
    logic [WAW-1:0] w_rd_addr;

    assign w_word_idx         = r_pc / AW'(BPI);
    assign w_in_range         = 32'(w_word_idx) < DEPTH;
    assign w_redir_misaligned = (redir_addr % AW'(BPI)) != '0;
    assign w_rd_addr          = w_word_idx[WAW-1:0];

    // A fetch happens only when RUN has no higher-priority event this cycle;
    // the memory read register then doubles as out_instr and holds otherwise.
    assign w_fetch  = (r_state == StRun) && !stop && !redir_valid && !stall && w_in_range;
    assign w_mem_we = ld_en && (r_state == StIdle);

    ins_mem #(
        .IW    (IW),
        .DEPTH (DEPTH),
        .WAW   (WAW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_waddr (ld_addr),
        .i_wdata (ld_data),
        .i_re    (w_fetch),
        .i_raddr (w_rd_addr),
        .o_rdata (out_instr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_pc        <= '0;
            r_out_pc    <= '0;
            r_out_valid <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (stop) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end else if (redir_valid) begin
                        r_out_valid <= 1'b0;
                        if (w_redir_misaligned) begin
                            r_fault <= 1'b1;
                            r_state <= StHalt;
                        end else begin
                            r_pc <= redir_addr;
                        end
                    end else if (stall) begin
                        // hold everything
                    end else if (!w_in_range) begin
                        // No wrap-around: running off the end is fatal.
                        r_out_valid <= 1'b0;
                        r_fault     <= 1'b1;
                        r_state     <= StHalt;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_out_pc    <= r_pc;
                        r_pc        <= r_pc + AW'(BPI);
                    end
                end
                StHalt: begin
                    r_out_valid <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign fault     = r_fault;
    assign busy      = (r_state == StRun);

endmodule
